// File: rtl/td_scheduler.sv
// rtl/td_scheduler.sv - round-robin arbiter/sequencer for the shared traffic/dice mux (optional hold preemption: TD_SCHED_PREEMPT_EN)
module td_scheduler #(
    parameter int TRAFFIC_CYCLES  = 8,
    parameter int DICE_MAX_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       traffic_req,
    input  logic       dice_req,
    input  logic       roll,
    input  logic [2:0] result_in,
    output logic       sel,
    output logic       mux_rst,
    output logic       button,
    output logic [2:0] display,
    output logic       grant_traffic,
    output logic       grant_dice,
    output logic       busy
);

`ifdef TD_SCHED_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    localparam logic [7:0] TRAFFIC_LAST = 8'(TRAFFIC_CYCLES - 1);
    localparam logic [7:0] DICE_LAST    = 8'(DICE_MAX_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWITCH,
        S_RUN_TRAFFIC,
        S_RUN_DICE,
        S_HOLD
    } state_t;

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_owner_q, last_owner_d;   // 1 = traffic owned the last slot
    logic [7:0] cnt_q, cnt_d;
    logic       rolled_q, rolled_d;
    logic [2:0] display_q, display_d;
    logic       pick_traffic;
    logic       in_run;

    // Single request wins outright; a tie goes to whoever did not own the last slot.
    assign pick_traffic = traffic_req & (~dice_req | ~last_owner_q);
    assign in_run       = (state_q == S_RUN_TRAFFIC) || (state_q == S_RUN_DICE);

    // State and datapath registers; reset aborts any slot immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            last_owner_q <= 1'b0;
            cnt_q        <= 8'd0;
            rolled_q     <= 1'b0;
            display_q    <= 3'b000;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            rolled_q     <= rolled_d;
            display_q    <= display_d;
        end
    end

    // Next-state logic: arbitration in IDLE, slot timing in RUN_*/HOLD.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        rolled_d     = rolled_q;
        display_d    = in_run ? result_in : display_q;

        case (state_q)
            S_IDLE: begin
                if (traffic_req || dice_req) begin
                    sel_d        = pick_traffic;
                    last_owner_d = pick_traffic;
                    state_d      = S_SWITCH;
                end
            end
            S_SWITCH: begin
                cnt_d   = 8'd0;
                state_d = sel_q ? S_RUN_TRAFFIC : S_RUN_DICE;
            end
            S_RUN_TRAFFIC: begin
                cnt_d = cnt_q + 8'd1;
                if ((cnt_q == TRAFFIC_LAST) || !traffic_req) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN_DICE: begin
                if (roll) begin
                    rolled_d = 1'b1;
                end
                if ((rolled_q && !roll) || (cnt_q == DICE_LAST)) begin
                    state_d = S_HOLD;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                cnt_d    = cnt_q + 8'd1;
                rolled_d = 1'b0;
                if ((cnt_q == HOLD_LAST) || (PREEMPT && traffic_req)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sel           = sel_q;
    assign display       = display_q;
    assign mux_rst       = (state_q == S_IDLE) || (state_q == S_SWITCH);
    assign button        = roll && (state_q == S_RUN_DICE);
    assign grant_traffic = sel_q && ((state_q == S_SWITCH) || (state_q == S_RUN_TRAFFIC));
    assign grant_dice    = !sel_q && ((state_q == S_SWITCH) || (state_q == S_RUN_DICE) ||
                                      (state_q == S_HOLD));
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_td_scheduler.sv
// tb/tb_td_scheduler.sv - scoreboard bench for td_scheduler (grants, display, slot and button lengths)
module tb_td_scheduler;

`ifdef TD_SCHED_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       traffic_req = 1'b0;
    logic       dice_req = 1'b0;
    logic       roll = 1'b0;
    logic [2:0] result_in = 3'b000;
    logic       sel, mux_rst, button, grant_traffic, grant_dice, busy;
    logic [2:0] display;

    int tests = 0;
    int fails = 0;

    int grant_q[$];
    int disp_q[$];
    int busy_q[$];
    int btn_q[$];

    td_scheduler dut (
        .clk(clk), .rst(rst), .traffic_req(traffic_req), .dice_req(dice_req),
        .roll(roll), .result_in(result_in), .sel(sel), .mux_rst(mux_rst),
        .button(button), .display(display), .grant_traffic(grant_traffic),
        .grant_dice(grant_dice), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        traffic_req = 1'b0;
        dice_req = 1'b0;
        roll = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares DUT events against the scoreboard queues.
    logic       prev_gt = 1'b0, prev_gd = 1'b0;
    logic [2:0] prev_disp = 3'b000;
    int         busy_len = 0, btn_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_gt   = grant_traffic;
            prev_gd   = grant_dice;
            prev_disp = display;
            busy_len  = 0;
            btn_len   = 0;
        end else begin
            if (grant_traffic && !prev_gt) begin
                if (grant_q.size() == 0) chk("grant_unexpected", 1, -1);
                else chk("grant_owner", 1, grant_q.pop_front());
            end
            if (grant_dice && !prev_gd) begin
                if (grant_q.size() == 0) chk("grant_unexpected", 0, -1);
                else chk("grant_owner", 0, grant_q.pop_front());
            end
            if (display != prev_disp) begin
                if (disp_q.size() == 0) chk("display_unexpected", int'(display), -1);
                else chk("display_value", int'(display), disp_q.pop_front());
            end
            if (busy) busy_len++;
            else if (busy_len > 0) begin
                if (busy_q.size() == 0) chk("busy_unexpected", busy_len, -1);
                else chk("busy_length", busy_len, busy_q.pop_front());
                busy_len = 0;
            end
            if (button) btn_len++;
            else if (btn_len > 0) begin
                if (btn_q.size() == 0) chk("button_unexpected", btn_len, -1);
                else chk("button_length", btn_len, btn_q.pop_front());
                btn_len = 0;
            end
            prev_gt   = grant_traffic;
            prev_gd   = grant_dice;
            prev_disp = display;
        end
    end

    initial begin
        logic [2:0] walk [8];
        walk = '{3'b100, 3'b110, 3'b001, 3'b010, 3'b100, 3'b110, 3'b001, 3'b010};

        // Reset state
        step(1);
        chk("rst_sel", sel, 0);
        chk("rst_display", display, 0);
        chk("rst_mux_rst", mux_rst, 1);
        chk("rst_button", button, 0);
        chk("rst_grant_traffic", grant_traffic, 0);
        chk("rst_grant_dice", grant_dice, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // 1: reset in the middle of RUN_DICE with roll held high
        grant_q.push_back(0);
        disp_q.push_back(5);
        dice_req = 1'b1;
        roll = 1'b1;
        result_in = 3'b101;
        step(4);
        rst = 1'b1;
        #1;
        chk("abort_mux_rst", mux_rst, 1);
        chk("abort_sel", sel, 0);
        chk("abort_display", display, 0);
        chk("abort_busy", busy, 0);
        chk("abort_button", button, 0);
        dice_req = 1'b0;
        roll = 1'b0;
        step(1);
        rst = 1'b0;

        // 2: traffic alone, result walks, display one clock late
        do_reset();
        grant_q.push_back(1);
        busy_q.push_back(9);
        for (int i = 0; i < 8; i++) disp_q.push_back(int'(walk[i]));
        traffic_req = 1'b1;
        result_in = 3'b000;
        step(1);
        chk("t2_sel_after_1clk", sel, 1);
        chk("t2_switch_mux_rst", mux_rst, 1);
        step(1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) chk("t2_display_lag", int'(display), int'(walk[i-1]));
            result_in = walk[i];
            if (i == 7) traffic_req = 1'b0;
            step(1);
        end
        chk("t2_idle_busy", busy, 0);
        chk("t2_final_display", display, 2);

        // 3: both requests held: traffic, dice, traffic
        do_reset();
        grant_q.push_back(1);
        grant_q.push_back(0);
        grant_q.push_back(1);
        busy_q.push_back(9);
        busy_q.push_back(21);
        busy_q.push_back(9);
        disp_q.push_back(3);
        result_in = 3'b011;
        traffic_req = 1'b1;
        dice_req = 1'b1;
        step(41);
        traffic_req = 1'b0;
        dice_req = 1'b0;
        step(2);
        chk("t3_idle_busy", busy, 0);

        // 4: roll three clocks then release, hold freezes display
        do_reset();
        grant_q.push_back(0);
        busy_q.push_back(9);
        btn_q.push_back(3);
        disp_q.push_back(5);
        disp_q.push_back(3);
        disp_q.push_back(6);
        disp_q.push_back(7);
        dice_req = 1'b1;
        result_in = 3'b101;
        step(2);
        roll = 1'b1;
        dice_req = 1'b0;
        step(1);
        result_in = 3'b011;
        step(1);
        result_in = 3'b110;
        step(1);
        roll = 1'b0;
        result_in = 3'b111;
        step(1);
        result_in = 3'b000;
        chk("t4_hold_mux_rst", mux_rst, 0);
        step(1);
        result_in = 3'b010;
        step(4);
        chk("t4_idle_busy", busy, 0);
        chk("t4_held_display", display, 7);

        // 5: roll held forever, roll window capped at 16 clocks
        do_reset();
        grant_q.push_back(0);
        busy_q.push_back(21);
        btn_q.push_back(16);
        disp_q.push_back(6);
        dice_req = 1'b1;
        roll = 1'b1;
        result_in = 3'b110;
        step(1);
        chk("t5_switch_button", button, 0);
        step(1);
        dice_req = 1'b0;
        step(16);
        chk("t5_hold_button", button, 0);
        chk("t5_hold_busy", busy, 1);
        step(4);
        chk("t5_idle_busy", busy, 0);
        roll = 1'b0;

        // 6: traffic request during the first HOLD cycle
        do_reset();
        grant_q.push_back(0);
        grant_q.push_back(1);
        busy_q.push_back(PRE ? 6 : 9);
        busy_q.push_back(2);
        btn_q.push_back(3);
        disp_q.push_back(5);
        dice_req = 1'b1;
        result_in = 3'b101;
        step(2);
        roll = 1'b1;
        dice_req = 1'b0;
        step(3);
        roll = 1'b0;
        step(1);
        traffic_req = 1'b1;
        step(1);
        chk("t6_busy_after_hold_c0", busy, PRE ? 0 : 1);
        step(PRE ? 2 : 5);
        chk("t6_traffic_sel", sel, 1);
        traffic_req = 1'b0;
        step(2);
        chk("t6_idle_busy", busy, 0);

        step(2);
        chk("grant_q_left", grant_q.size(), 0);
        chk("disp_q_left", disp_q.size(), 0);
        chk("busy_q_left", busy_q.size(), 0);
        chk("btn_q_left", btn_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
